// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file BIST controller, its checker
// and anything that injects faults into the register file.
package regfile_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      WRI,
      RDI,
      DONE
   } bist_state_e;

   localparam logic PHASE_TRUE = 1'b0;
   localparam logic PHASE_INV  = 1'b1;

   localparam logic [1:0] FT_NONE = 2'd0;
   localparam logic [1:0] FT_FLIP = 2'd1;
   localparam logic [1:0] FT_SA0  = 2'd2;
   localparam logic [1:0] FT_SA1  = 2'd3;

endpackage

// File: rtl/regfile_bist_chk.sv
// Two-port read comparator with a saturating mismatch counter and capture of
// the first mismatching read of a run.
module regfile_bist_chk
   import regfile_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ADDRW = 5,
   parameter int ERRW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             rd_en,
   input  logic             phase,
   input  logic [ADDRW-1:0] addr,
   input  logic [WIDTH-1:0] expected,
   input  logic [WIDTH-1:0] rdata1,
   input  logic [WIDTH-1:0] rdata2,
   output logic [ERRW-1:0]  err_count,
   output logic [ADDRW-1:0] first_err_addr,
   output logic             first_err_phase,
   output logic [WIDTH-1:0] first_err_data
);

   logic       mis1;
   logic       mis2;
   logic [1:0] mis_cnt;
   logic       seen;

   // The extra top bit of the sum flags overflow, since at most 2 is added.
   function automatic logic [ERRW-1:0] sat_add(input logic [ERRW-1:0] a,
                                                input logic [1:0]      b);
      logic [ERRW:0] s;
      s = {1'b0, a} + {{(ERRW - 1){1'b0}}, b};
      if (s[ERRW]) return '1;
      return s[ERRW-1:0];
   endfunction

   always_comb begin
      mis1    = rd_en && (rdata1 != expected);
      mis2    = rd_en && (rdata2 != expected);
      mis_cnt = {1'b0, mis1} + {1'b0, mis2};
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_count       <= '0;
         first_err_addr  <= '0;
         first_err_phase <= PHASE_TRUE;
         first_err_data  <= '0;
         seen            <= 1'b0;
      end else if (mis1 || mis2) begin
         err_count <= sat_add(err_count, mis_cnt);
         if (!seen) begin
            seen            <= 1'b1;
            first_err_addr  <= addr;
            first_err_phase <= phase;
            first_err_data  <= mis1 ? rdata1 : rdata2;
         end
      end
   end

endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST: write P, read P, write ~P, read ~P over every address,
// scoring mismatches in the checker. All rf_* outputs decode from registers.
module regfile_bist
   import regfile_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int ADDRW = $clog2(DEPTH),
   parameter int ERRW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERRW-1:0]  err_count,
   output logic [ADDRW-1:0] first_err_addr,
   output logic             first_err_phase,
   output logic [WIDTH-1:0] first_err_data,
   output logic             rf_we,
   output logic [ADDRW-1:0] rf_waddr,
   output logic [WIDTH-1:0] rf_wdata,
   output logic [ADDRW-1:0] rf_raddr1,
   output logic [ADDRW-1:0] rf_raddr2,
   input  logic [WIDTH-1:0] rf_rdata1,
   input  logic [WIDTH-1:0] rf_rdata2
);

   bist_state_e      state;
   bist_state_e      state_next;
   logic [ADDRW-1:0] addr;
   logic [WIDTH-1:0] pat;
   logic             last;
   logic             accept;
   logic             wr;
   logic             rd;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] expected;

   always_comb begin
      last       = (addr == ADDRW'(DEPTH - 1));
      accept     = start && ((state == IDLE) || (state == DONE));
      state_next = state;
      case (state)
         IDLE, DONE: if (start) state_next = WR;
         WR:         if (last)  state_next = RD;
         RD:         if (last)  state_next = WRI;
         WRI:        if (last)  state_next = RDI;
         RDI:        if (last)  state_next = DONE;
         default:               state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr  <= '0;
      end else begin
         state <= state_next;
         if (accept)
            addr <= '0;
         else if (wr || rd)
            addr <= last ? '0 : addr + ADDRW'(1);
      end
   end

   // Pattern is data: only the accepting edge loads it, reset leaves it alone.
   always_ff @(posedge clk) begin
      if (accept) pat <= pattern;
   end

   always_comb begin
      wr        = (state == WR) || (state == WRI);
      rd        = (state == RD) || (state == RDI);
      cur       = ((state == WRI) || (state == RDI)) ? ~pat : pat;
      expected  = (addr == '0) ? '0 : cur;
      rf_we     = wr;
      rf_waddr  = wr ? addr : '0;
      rf_wdata  = wr ? cur  : '0;
      rf_raddr1 = rd ? addr : '0;
      rf_raddr2 = rd ? addr : '0;
      busy      = wr || rd;
      done      = (state == DONE);
      pass      = done && (err_count == '0);
   end

   regfile_bist_chk #(
      .WIDTH(WIDTH),
      .ADDRW(ADDRW),
      .ERRW (ERRW)
   ) u_chk (
      .clk            (clk),
      .rst            (rst),
      .clear          (accept),
      .rd_en          (rd),
      .phase          ((state == RDI) ? PHASE_INV : PHASE_TRUE),
      .addr           (addr),
      .expected       (expected),
      .rdata1         (rf_rdata1),
      .rdata2         (rf_rdata2),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .first_err_phase(first_err_phase),
      .first_err_data (first_err_data)
   );

endmodule
